// File: rtl/dlx_pkg.sv
// Shared types and default widths for the DLX memory-port arbiter.
package dlx_pkg;

  localparam int unsigned DLX_ADDR_W = 32;
  localparam int unsigned DLX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } arb_state_t;

  typedef enum logic {
    SRC_IF,
    SRC_MEM
  } arb_src_t;

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Requester and RAM signal bundle of the DLX memory arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/RAM view.
interface dlx_mem_arbiter_if
  import dlx_pkg::*;
#(
  parameter int unsigned ADDR_W = DLX_ADDR_W,
  parameter int unsigned DATA_W = DLX_DATA_W
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BE_W-1:0]   ram_be;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  logic              err;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  ram_ack, ram_rdata,
    output if_gnt, if_done, if_rdata,
    output mem_gnt, mem_done, mem_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_be,
    output err
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output ram_ack, ram_rdata,
    input  if_gnt, if_done, if_rdata,
    input  mem_gnt, mem_done, mem_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_be,
    input  err
  );

endinterface

// File: rtl/dlx_arb_wdog.sv
// Loadable saturating BUSY-cycle counter; reached_c flags the last allowed cycle
// so the arbiter can abort at the edge that closes the TIMEOUT_CYC-th BUSY cycle.
module dlx_arb_wdog #(
  parameter  int unsigned TIMEOUT_CYC = 15,
  localparam int unsigned CW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          reached_c
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != CW'(TIMEOUT_CYC))) begin
      count <= count + CW'(1);
    end
  end

  // Count starts at 0 in the first BUSY cycle, so TIMEOUT_CYC-1 marks the final one.
  assign reached_c = en && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the single DLX RAM port between instruction fetch and data access.
// Define DLX_ARB_RR_EN for round-robin tie breaking; otherwise MEM wins every tie.
module dlx_mem_arbiter
  import dlx_pkg::*;
#(
  parameter int unsigned ADDR_W      = DLX_ADDR_W,
  parameter int unsigned DATA_W      = DLX_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic                clk,
  input logic                reset,
  dlx_mem_arbiter_if.master  bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              grant_if;
  logic              grant_mem;
  logic              wd_reached_c;

`ifdef DLX_ARB_RR_EN
  arb_src_t          last_src;
`endif

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_be    = be_q;

  // Pick the winner for this IDLE cycle.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (bus.if_req && bus.mem_req) begin
`ifdef DLX_ARB_RR_EN
      if (last_src == SRC_MEM) grant_if  = 1'b1;
      else                     grant_mem = 1'b1;
`else
      grant_mem = 1'b1;
`endif
    end else begin
      grant_if  = bus.if_req;
      grant_mem = bus.mem_req;
    end
  end

  dlx_arb_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == IDLE),
    .en        (state != IDLE),
    .load      (1'b0),
    .load_val  ('0),
    .reached_c (wd_reached_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_gnt   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= '0;
      bus.err       <= 1'b0;
`ifdef DLX_ARB_RR_EN
      last_src      <= SRC_MEM;
`endif
    end else begin
      bus.if_gnt   <= 1'b0;
      bus.mem_gnt  <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      bus.err      <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_mem) begin
            state       <= BUSY_MEM;
            bus.mem_gnt <= 1'b1;
            bus.ram_req <= 1'b1;
            bus.ram_we  <= bus.mem_we;
            addr_q      <= bus.mem_addr;
            wdata_q     <= bus.mem_wdata;
            be_q        <= bus.mem_be;
`ifdef DLX_ARB_RR_EN
            last_src    <= SRC_MEM;
`endif
          end else if (grant_if) begin
            state       <= BUSY_IF;
            bus.if_gnt  <= 1'b1;
            bus.ram_req <= 1'b1;
            bus.ram_we  <= 1'b0;
            addr_q      <= bus.if_addr;
            wdata_q     <= '0;
            be_q        <= '1;
`ifdef DLX_ARB_RR_EN
            last_src    <= SRC_IF;
`endif
          end
        end

        BUSY_IF, BUSY_MEM: begin
          // An ack arriving on the watchdog's last cycle still completes normally.
          if (bus.ram_ack || wd_reached_c) begin
            state       <= IDLE;
            bus.ram_req <= 1'b0;
            bus.ram_we  <= 1'b0;
            bus.err     <= !bus.ram_ack;
            if (state == BUSY_IF) begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= bus.ram_ack ? bus.ram_rdata : '0;
            end else begin
              bus.mem_done  <= 1'b1;
              bus.mem_rdata <= (bus.ram_ack && !bus.ram_we) ? bus.ram_rdata : '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: a table of single transactions plus
// hand-written tie, reset-abort and idle-ack sequences.
module tb_dlx_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dlx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dlx_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          is_mem;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int unsigned   ack_cyc;   // BUSY cycle carrying ram_ack, 0 = never
    logic [DW-1:0] rdata;     // value on ram_rdata throughout BUSY
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [7];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One request, held until grant, acked (or not) on a chosen BUSY cycle.
  task automatic run_txn(input string tag, input vec_t v);
    int unsigned k;
    @(negedge clk);
    if (v.is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = v.we;
      bus.mem_addr  = v.addr;
      bus.mem_wdata = v.wdata;
      bus.mem_be    = v.be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    @(negedge clk);
    chk1({tag, "_gnt"}, v.is_mem ? bus.mem_gnt : bus.if_gnt, 1'b1);
    chk1({tag, "_other_gnt"}, v.is_mem ? bus.if_gnt : bus.mem_gnt, 1'b0);
    chk1({tag, "_ram_we"}, bus.ram_we, v.is_mem ? v.we : 1'b0);
    chk({tag, "_ram_addr"}, bus.ram_addr, v.addr);
    chk({tag, "_ram_be"}, DW'(bus.ram_be), v.is_mem ? DW'(v.be) : DW'({BW{1'b1}}));
    if (v.is_mem) chk({tag, "_ram_wdata"}, bus.ram_wdata, v.wdata);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    k = 1;
    while (1) begin
      bus.ram_ack   = (k == v.ack_cyc);
      bus.ram_rdata = v.rdata;
      chk1({tag, "_busy_ram_req"}, bus.ram_req, 1'b1);
      chk1({tag, "_busy_no_done"}, bus.if_done | bus.mem_done | bus.err, 1'b0);
      if (k > 1) chk1({tag, "_gnt_single"}, bus.if_gnt | bus.mem_gnt, 1'b0);
      if (k == v.ack_cyc || k == TO) break;
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    chk1({tag, "_done"}, v.is_mem ? bus.mem_done : bus.if_done, 1'b1);
    chk1({tag, "_other_done"}, v.is_mem ? bus.if_done : bus.mem_done, 1'b0);
    chk({tag, "_rdata"}, v.is_mem ? bus.mem_rdata : bus.if_rdata, v.exp_rdata);
    chk1({tag, "_err"}, bus.err, v.exp_err);
    chk1({tag, "_idle_ram_req"}, bus.ram_req, 1'b0);
    @(negedge clk);
    chk1({tag, "_pulse_end"}, bus.if_done | bus.mem_done | bus.err, 1'b0);
    chk({tag, "_rdata_hold"}, v.is_mem ? bus.mem_rdata : bus.if_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic          win_if;
    logic [DW-1:0] prev_rdata;

    //           mem   we    addr          wdata         be    ack rdata         exp_rdata     err
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 1,  32'hAAAA_5555, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h5A5A_0000, 4'h3, 2,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,        4'h0, 0,  32'h1111_1111, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,        4'h0, 15, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'hC, 0,  32'h2222_2222, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 1,  32'h0000_0013, 32'h0000_0013, 1'b0};

    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    do_reset();

    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst_mem_gnt", bus.mem_gnt, 1'b0);
    chk1("rst_done", bus.if_done | bus.mem_done, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_ram_req", bus.ram_req, 1'b0);
    chk1("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk("rst_ram_be", DW'(bus.ram_be), 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);

    for (int i = 0; i < 7; i++) run_txn($sformatf("v%0d", i), vecs[i]);

    // Both requesters hold req continuously: every IDLE cycle is a tie.
    do_reset();
    @(negedge clk);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0500;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0600;
    bus.mem_be   = 4'hF;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
`ifdef DLX_ARB_RR_EN
      win_if = (t % 2 == 0);
`else
      win_if = 1'b0;
`endif
      chk1($sformatf("tie%0d_if_gnt", t), bus.if_gnt, win_if);
      chk1($sformatf("tie%0d_mem_gnt", t), bus.mem_gnt, !win_if);
      chk($sformatf("tie%0d_ram_addr", t), bus.ram_addr, win_if ? 32'h0000_0500 : 32'h0000_0600);
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'hA000_0000 + DW'(t);
      @(negedge clk);
      bus.ram_ack = 1'b0;
      chk1($sformatf("tie%0d_done", t), win_if ? bus.if_done : bus.mem_done, 1'b1);
      chk($sformatf("tie%0d_rdata", t), win_if ? bus.if_rdata : bus.mem_rdata,
          32'hA000_0000 + DW'(t));
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Reset in the second BUSY cycle abandons the fetch silently.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0700;
    @(negedge clk);
    chk1("rstmid_gnt", bus.if_gnt, 1'b1);
    bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("rstmid_ram_req", bus.ram_req, 1'b0);
    chk1("rstmid_done", bus.if_done | bus.mem_done, 1'b0);
    chk1("rstmid_err", bus.err, 1'b0);
    @(negedge clk);
    chk1("rstmid_done_after", bus.if_done | bus.mem_done | bus.err, 1'b0);
    chk1("rstmid_still_idle", bus.ram_req, 1'b0);
    run_txn("rstmid_next", vecs[2]);

    // ram_ack while IDLE must be ignored.
    prev_rdata = bus.mem_rdata;
    @(negedge clk);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    chk1("idleack_done", bus.if_done | bus.mem_done, 1'b0);
    chk1("idleack_err", bus.err, 1'b0);
    chk1("idleack_ram_req", bus.ram_req, 1'b0);
    chk("idleack_mem_rdata", bus.mem_rdata, prev_rdata);
    run_txn("idleack_next", vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
